// File: rtl/control_unit_pkg.sv
// Shared encodings for the THCO-MIPS16 multi-cycle control unit: FSM states,
// instruction codes, ALU/extend codes, special register indices and the decoded field bundle.
package control_unit_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    typedef enum logic [5:0] {
        INS_NOP    = 6'd0,
        INS_ADDIU  = 6'd1,
        INS_ADDIU3 = 6'd2,
        INS_ADDSP  = 6'd3,
        INS_ADDU   = 6'd4,
        INS_SUBU   = 6'd5,
        INS_AND    = 6'd6,
        INS_OR     = 6'd7,
        INS_CMP    = 6'd8,
        INS_B      = 6'd9,
        INS_BEQZ   = 6'd10,
        INS_BNEZ   = 6'd11,
        INS_BTEQZ  = 6'd12,
        INS_JR     = 6'd13,
        INS_LI     = 6'd14,
        INS_LW     = 6'd15,
        INS_LW_SP  = 6'd16,
        INS_SW     = 6'd17,
        INS_SW_SP  = 6'd18,
        INS_SLL    = 6'd19,
        INS_SRA    = 6'd20,
        INS_MFIH   = 6'd21,
        INS_MTIH   = 6'd22,
        INS_MFPC   = 6'd23,
        INS_MTSP   = 6'd24
    } ins_e;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_SLL    = 5'd4,
        ALU_SRA    = 5'd5,
        ALU_NEQ    = 5'd6,
        ALU_PASS_A = 5'd7,
        ALU_PASS_B = 5'd8
    } alu_e;

    typedef enum logic [2:0] {
        EXT_NONE  = 3'd0,
        EXT_S8    = 3'd1,
        EXT_Z8    = 3'd2,
        EXT_S4    = 3'd3,
        EXT_S11   = 3'd4,
        EXT_SHAMT = 3'd5,
        EXT_S5    = 3'd6
    } ext_e;

    localparam logic [3:0] REG_T    = 4'b1000;
    localparam logic [3:0] REG_SP   = 4'b1001;
    localparam logic [3:0] REG_IH   = 4'b1010;
    localparam logic [3:0] REG_NONE = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_LMD = 2'b01;
    localparam logic [1:0] WB_NPC = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] JMP_NONE   = 2'b00;
    localparam logic [1:0] JMP_UNCOND = 2'b01;
    localparam logic [1:0] JMP_COND   = 2'b10;
    localparam logic [1:0] JMP_REG    = 2'b11;

    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_B      = 5'b00010;
    localparam logic [4:0] OP_BEQZ   = 5'b00100;
    localparam logic [4:0] OP_BNEZ   = 5'b00101;
    localparam logic [4:0] OP_SHIFT  = 5'b00110;
    localparam logic [4:0] OP_ADDIU3 = 5'b01000;
    localparam logic [4:0] OP_ADDIU  = 5'b01001;
    localparam logic [4:0] OP_SPGRP  = 5'b01100;
    localparam logic [4:0] OP_LI     = 5'b01101;
    localparam logic [4:0] OP_LW_SP  = 5'b10010;
    localparam logic [4:0] OP_LW     = 5'b10011;
    localparam logic [4:0] OP_SW_SP  = 5'b11010;
    localparam logic [4:0] OP_SW     = 5'b11011;
    localparam logic [4:0] OP_RRR    = 5'b11100;
    localparam logic [4:0] OP_RR     = 5'b11101;
    localparam logic [4:0] OP_IH     = 5'b11110;

    typedef struct packed {
        logic [3:0] wt;
        logic [3:0] src_a;
        logic [3:0] src_b;
        ext_e       ext;
        alu_e       alu;
        logic       mux1;
        logic       mux2;
        logic [1:0] mux4;
        logic [1:0] jump;
        logic       cond;
    } dec_t;

    localparam dec_t DEC_DEFAULT = '{
        wt: REG_NONE, src_a: REG_NONE, src_b: REG_NONE,
        ext: EXT_NONE, alu: ALU_ADD, mux1: 1'b0, mux2: 1'b0,
        mux4: WB_ALU, jump: JMP_NONE, cond: 1'b0
    };

    function automatic logic [3:0] gpr(input logic [2:0] field);
        return {1'b0, field};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: the IR word in, every latch enable, select and
// register index out. master is the control unit, slave is the datapath.
interface control_unit_if;
    logic [15:0] IR_in;
    logic [2:0]  state;
    logic [5:0]  cur_ins;
    logic        Load_NPC;
    logic        Load_PC;
    logic        Load_IR;
    logic        Load_RegA;
    logic        Load_RegB;
    logic        Load_Imm;
    logic        Load_ALU;
    logic        Load_LMD;
    logic        Write;
    logic [3:0]  WT_Reg;
    logic [7:0]  Send_Reg;
    logic [2:0]  Extend;
    logic [4:0]  Cal_ALU;
    logic        Sel_Mux1;
    logic        Sel_Mux2;
    logic [1:0]  Sel_Mux4;
    logic [1:0]  Jump_Kind;
    logic        Cond_Kind;

    modport master (
        input  IR_in,
        output state, cur_ins,
        output Load_NPC, Load_PC, Load_IR, Load_RegA, Load_RegB, Load_Imm, Load_ALU, Load_LMD,
        output Write, WT_Reg, Send_Reg, Extend, Cal_ALU,
        output Sel_Mux1, Sel_Mux2, Sel_Mux4, Jump_Kind, Cond_Kind
    );

    modport slave (
        output IR_in,
        input  state, cur_ins,
        input  Load_NPC, Load_PC, Load_IR, Load_RegA, Load_RegB, Load_Imm, Load_ALU, Load_LMD,
        input  Write, WT_Reg, Send_Reg, Extend, Cal_ALU,
        input  Sel_Mux1, Sel_Mux2, Sel_Mux4, Jump_Kind, Cond_Kind
    );
endinterface

// File: rtl/control_unit_decoder.sv
// Purely combinational instruction decoder: IR word -> instruction code plus
// the per-instruction datapath fields. State gating happens in the top.
module control_decoder
    import control_unit_pkg::*;
(
    input  logic [15:0] ir_i,
    output ins_e        cur_ins_o,
    output dec_t        dec_o
);
    logic [4:0] op;
    logic [3:0] rx;
    logic [3:0] ry;
    logic [3:0] rz;

    assign op = ir_i[15:11];
    assign rx = gpr(ir_i[10:8]);
    assign ry = gpr(ir_i[7:5]);
    assign rz = gpr(ir_i[4:2]);

    always_comb begin
        cur_ins_o = INS_NOP;
        dec_o     = DEC_DEFAULT;
        case (op)
            OP_ADDIU: begin
                cur_ins_o = INS_ADDIU;
                dec_o.wt = rx; dec_o.src_a = rx; dec_o.ext = EXT_S8; dec_o.mux2 = 1'b1;
            end
            OP_ADDIU3: begin
                cur_ins_o = INS_ADDIU3;
                dec_o.wt = ry; dec_o.src_a = rx; dec_o.ext = EXT_S4; dec_o.mux2 = 1'b1;
            end
            OP_SPGRP: begin
                // [10:8] selects among the SP/T-based instructions sharing this opcode
                case (ir_i[10:8])
                    3'b011: begin
                        cur_ins_o = INS_ADDSP;
                        dec_o.wt = REG_SP; dec_o.src_a = REG_SP; dec_o.ext = EXT_S8; dec_o.mux2 = 1'b1;
                    end
                    3'b000: begin
                        cur_ins_o = INS_BTEQZ;
                        dec_o.src_a = REG_T; dec_o.ext = EXT_S8; dec_o.mux1 = 1'b1; dec_o.mux2 = 1'b1;
                        dec_o.jump = JMP_COND; dec_o.cond = 1'b0;
                    end
                    3'b100: begin
                        cur_ins_o = INS_MTSP;
                        dec_o.wt = REG_SP; dec_o.src_a = ry; dec_o.alu = ALU_PASS_A;
                    end
                    default: ;
                endcase
            end
            OP_RRR: begin
                if (ir_i[1:0] == 2'b01 || ir_i[1:0] == 2'b11) begin
                    cur_ins_o = (ir_i[1]) ? INS_SUBU : INS_ADDU;
                    dec_o.alu = (ir_i[1]) ? ALU_SUB : ALU_ADD;
                    dec_o.wt = rz; dec_o.src_a = rx; dec_o.src_b = ry;
                end
            end
            OP_RR: begin
                // Full low byte first: JR and MFPC both have [4:0] = 0
                if (ir_i[7:0] == 8'h00) begin
                    cur_ins_o = INS_JR;
                    dec_o.src_a = rx; dec_o.jump = JMP_REG;
                end else if (ir_i[7:0] == 8'h40) begin
                    cur_ins_o = INS_MFPC;
                    dec_o.wt = rx; dec_o.mux4 = WB_NPC;
                end else begin
                    case (ir_i[4:0])
                        5'b01100: begin
                            cur_ins_o = INS_AND;
                            dec_o.wt = rx; dec_o.src_a = rx; dec_o.src_b = ry; dec_o.alu = ALU_AND;
                        end
                        5'b01101: begin
                            cur_ins_o = INS_OR;
                            dec_o.wt = rx; dec_o.src_a = rx; dec_o.src_b = ry; dec_o.alu = ALU_OR;
                        end
                        5'b01010: begin
                            cur_ins_o = INS_CMP;
                            dec_o.wt = REG_T; dec_o.src_a = rx; dec_o.src_b = ry; dec_o.alu = ALU_NEQ;
                        end
                        default: ;
                    endcase
                end
            end
            OP_B: begin
                cur_ins_o = INS_B;
                dec_o.ext = EXT_S11; dec_o.mux1 = 1'b1; dec_o.mux2 = 1'b1; dec_o.jump = JMP_UNCOND;
            end
            OP_BEQZ, OP_BNEZ: begin
                cur_ins_o = (op[0]) ? INS_BNEZ : INS_BEQZ;
                dec_o.src_a = rx; dec_o.ext = EXT_S8; dec_o.mux1 = 1'b1; dec_o.mux2 = 1'b1;
                dec_o.jump = JMP_COND; dec_o.cond = op[0];
            end
            OP_LI: begin
                cur_ins_o = INS_LI;
                dec_o.wt = rx; dec_o.ext = EXT_Z8; dec_o.mux4 = WB_IMM;
            end
            OP_LW: begin
                cur_ins_o = INS_LW;
                dec_o.wt = ry; dec_o.src_a = rx; dec_o.ext = EXT_S5; dec_o.mux2 = 1'b1; dec_o.mux4 = WB_LMD;
            end
            OP_SW: begin
                cur_ins_o = INS_SW;
                dec_o.src_a = rx; dec_o.src_b = ry; dec_o.ext = EXT_S5; dec_o.mux2 = 1'b1;
            end
            OP_LW_SP: begin
                cur_ins_o = INS_LW_SP;
                dec_o.wt = rx; dec_o.src_a = REG_SP; dec_o.ext = EXT_S8; dec_o.mux2 = 1'b1; dec_o.mux4 = WB_LMD;
            end
            OP_SW_SP: begin
                cur_ins_o = INS_SW_SP;
                dec_o.src_a = REG_SP; dec_o.src_b = rx; dec_o.ext = EXT_S8; dec_o.mux2 = 1'b1;
            end
            OP_SHIFT: begin
                if (ir_i[1:0] == 2'b00 || ir_i[1:0] == 2'b11) begin
                    cur_ins_o = (ir_i[0]) ? INS_SRA : INS_SLL;
                    dec_o.alu = (ir_i[0]) ? ALU_SRA : ALU_SLL;
                    dec_o.wt = rx; dec_o.src_a = ry; dec_o.ext = EXT_SHAMT; dec_o.mux2 = 1'b1;
                end
            end
            OP_IH: begin
                if (ir_i[7:0] == 8'h00) begin
                    cur_ins_o = INS_MFIH;
                    dec_o.wt = rx; dec_o.src_a = REG_IH; dec_o.alu = ALU_PASS_A;
                end else if (ir_i[7:0] == 8'h01) begin
                    cur_ins_o = INS_MTIH;
                    dec_o.wt = REG_IH; dec_o.src_a = rx; dec_o.alu = ALU_PASS_A;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// Five-state IF/ID/EXE/MEM/WB sequencer; gates the decoder's fields and the
// per-state latch enables onto the datapath bundle.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);
    state_e state_q;
    state_e state_d;
    ins_e   ins;
    dec_t   dec;

    control_decoder u_decoder (
        .ir_i      (bus.IR_in),
        .cur_ins_o (ins),
        .dec_o     (dec)
    );

    always_comb begin
        case (state_q)
            ST_IF:   state_d = ST_ID;
            ST_ID:   state_d = ST_EXE;
            ST_EXE:  state_d = ST_MEM;
            ST_MEM:  state_d = ST_WB;
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.cur_ins = ins;

    always_comb begin
        bus.Load_NPC  = 1'b0;
        bus.Load_PC   = 1'b0;
        bus.Load_IR   = 1'b0;
        bus.Load_RegA = 1'b0;
        bus.Load_RegB = 1'b0;
        bus.Load_Imm  = 1'b0;
        bus.Load_ALU  = 1'b0;
        bus.Load_LMD  = 1'b0;
        bus.Write     = 1'b0;
        bus.WT_Reg    = REG_NONE;
        bus.Send_Reg  = {REG_NONE, REG_NONE};
        bus.Extend    = EXT_NONE;
        bus.Cal_ALU   = ALU_ADD;
        bus.Sel_Mux1  = 1'b0;
        bus.Sel_Mux2  = 1'b0;
        bus.Sel_Mux4  = WB_ALU;
        bus.Jump_Kind = JMP_NONE;
        bus.Cond_Kind = 1'b0;
        // Holding reset low masks every strobe immediately, even mid-instruction
        if (rst) begin
            case (state_q)
                ST_IF: begin
                    bus.Load_IR  = 1'b1;
                    bus.Load_NPC = 1'b1;
                end
                ST_ID: begin
                    bus.Load_RegA = 1'b1;
                    bus.Load_RegB = 1'b1;
                    bus.Load_Imm  = 1'b1;
                end
                ST_EXE: bus.Load_ALU = 1'b1;
                ST_MEM: begin
                    bus.Load_LMD = (ins == INS_LW) || (ins == INS_LW_SP);
                    bus.Write    = (ins == INS_SW) || (ins == INS_SW_SP);
                end
                ST_WB: begin
                    bus.Load_PC = 1'b1;
                    bus.WT_Reg  = dec.wt;
                end
                default: ;
            endcase
            if (state_q inside {ST_ID, ST_EXE, ST_MEM, ST_WB}) begin
                bus.Send_Reg  = {dec.src_a, dec.src_b};
                bus.Extend    = dec.ext;
                bus.Cal_ALU   = dec.alu;
                bus.Sel_Mux1  = dec.mux1;
                bus.Sel_Mux2  = dec.mux2;
                bus.Sel_Mux4  = dec.mux4;
                bus.Jump_Kind = dec.jump;
                bus.Cond_Kind = dec.cond;
            end
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks hand-decoded instructions through all
// five states and checks reset, including a reset asserted during MEM.
module tb_control_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task tick();
        @(posedge clk);
        #2;
    endtask

    // Entered and left with the FSM sitting in IF
    task run_insn(input logic [15:0] ir, input logic [5:0] ins, input logic [3:0] wt,
                  input logic [7:0] src, input logic [2:0] ext, input logic [4:0] alu,
                  input logic m1, input logic m2, input logic [1:0] m4,
                  input logic [1:0] jk, input logic ck, input logic lmd, input logic wr);
        bus.IR_in = ir;
        #1;
        chk("if_state",  32'(bus.state), 32'd0);
        chk("if_ld_ir",  32'(bus.Load_IR), 32'd1);
        chk("if_ld_npc", 32'(bus.Load_NPC), 32'd1);
        chk("if_send",   32'(bus.Send_Reg), 32'hFF);
        chk("if_ext",    32'(bus.Extend), 32'd0);
        chk("if_jump",   32'(bus.Jump_Kind), 32'd0);
        chk("if_wt",     32'(bus.WT_Reg), 32'hF);
        tick();
        chk("id_state",  32'(bus.state), 32'd1);
        chk("id_ins",    32'(bus.cur_ins), 32'(ins));
        chk("id_ld_ab",  32'({bus.Load_RegA, bus.Load_RegB, bus.Load_Imm, bus.Load_IR}), 32'b1110);
        chk("id_send",   32'(bus.Send_Reg), 32'(src));
        chk("id_ext",    32'(bus.Extend), 32'(ext));
        chk("id_jump",   32'(bus.Jump_Kind), 32'(jk));
        chk("id_cond",   32'(bus.Cond_Kind), 32'(ck));
        tick();
        chk("exe_state", 32'(bus.state), 32'd2);
        chk("exe_ld_alu", 32'(bus.Load_ALU), 32'd1);
        chk("exe_alu",   32'(bus.Cal_ALU), 32'(alu));
        chk("exe_mux1",  32'(bus.Sel_Mux1), 32'(m1));
        chk("exe_mux2",  32'(bus.Sel_Mux2), 32'(m2));
        chk("exe_ext",   32'(bus.Extend), 32'(ext));
        tick();
        chk("mem_state", 32'(bus.state), 32'd3);
        chk("mem_lmd",   32'(bus.Load_LMD), 32'(lmd));
        chk("mem_write", 32'(bus.Write), 32'(wr));
        chk("mem_wt",    32'(bus.WT_Reg), 32'hF);
        tick();
        chk("wb_state",  32'(bus.state), 32'd4);
        chk("wb_ld_pc",  32'(bus.Load_PC), 32'd1);
        chk("wb_wt",     32'(bus.WT_Reg), 32'(wt));
        chk("wb_mux4",   32'(bus.Sel_Mux4), 32'(m4));
        chk("wb_write",  32'(bus.Write), 32'd0);
        tick();
        $display("insn ir=%h cur_ins=%0d total=%0d bad=%0d", ir, ins, total, bad);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        bus.IR_in = 16'h0800;
        tick();
        tick();
        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_ld_ir",  32'(bus.Load_IR), 32'd0);
        chk("rst_ld_npc", 32'(bus.Load_NPC), 32'd0);
        chk("rst_send",   32'(bus.Send_Reg), 32'hFF);
        chk("rst_wt",     32'(bus.WT_Reg), 32'hF);
        $display("reset held 2 cycles total=%0d bad=%0d", total, bad);
        rst = 1'b1;

        //        ir        ins   wt     src    ext   alu   m1 m2 m4 jk ck lmd wr
        run_insn(16'h6908, 6'd14, 4'h1, 8'hFF, 3'd2, 5'd0, 0, 0, 2'd3, 2'd0, 0, 0, 0); // LI R1,8
        run_insn(16'h119A, 6'd9,  4'hF, 8'hFF, 3'd4, 5'd0, 1, 1, 2'd0, 2'd1, 0, 0, 0); // B
        run_insn(16'h2155, 6'd10, 4'hF, 8'h1F, 3'd1, 5'd0, 1, 1, 2'd0, 2'd2, 0, 0, 0); // BEQZ R1
        run_insn(16'h2A00, 6'd11, 4'hF, 8'h2F, 3'd1, 5'd0, 1, 1, 2'd0, 2'd2, 1, 0, 0); // BNEZ R2
        run_insn(16'hE171, 6'd4,  4'h4, 8'h13, 3'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0); // ADDU R1,R3,R4
        run_insn(16'hE0B9, 6'd4,  4'h6, 8'h05, 3'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0); // ADDU R0,R5,R6
        run_insn(16'hE0BB, 6'd5,  4'h6, 8'h05, 3'd0, 5'd1, 0, 0, 2'd0, 2'd0, 0, 0, 0); // SUBU R0,R5,R6
        run_insn(16'hEB8A, 6'd8,  4'h8, 8'h34, 3'd0, 5'd6, 0, 0, 2'd0, 2'd0, 0, 0, 0); // CMP R3,R4
        run_insn(16'hED00, 6'd13, 4'hF, 8'h5F, 3'd0, 5'd0, 0, 0, 2'd0, 2'd3, 0, 0, 0); // JR R5
        run_insn(16'hEA40, 6'd23, 4'h2, 8'hFF, 3'd0, 5'd0, 0, 0, 2'd2, 2'd0, 0, 0, 0); // MFPC R2
        run_insn(16'h9A45, 6'd15, 4'h2, 8'h2F, 3'd6, 5'd0, 0, 1, 2'd1, 2'd0, 0, 1, 0); // LW
        run_insn(16'hDA45, 6'd17, 4'hF, 8'h22, 3'd6, 5'd0, 0, 1, 2'd0, 2'd0, 0, 0, 1); // SW
        run_insn(16'h9304, 6'd16, 4'h3, 8'h9F, 3'd1, 5'd0, 0, 1, 2'd1, 2'd0, 0, 1, 0); // LW_SP
        run_insn(16'hD400, 6'd18, 4'hF, 8'h94, 3'd1, 5'd0, 0, 1, 2'd0, 2'd0, 0, 0, 1); // SW_SP
        run_insn(16'h63FF, 6'd3,  4'h9, 8'h9F, 3'd1, 5'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0); // ADDSP
        run_insn(16'h6005, 6'd12, 4'hF, 8'h8F, 3'd1, 5'd0, 1, 1, 2'd0, 2'd2, 0, 0, 0); // BTEQZ
        run_insn(16'h64C0, 6'd24, 4'h9, 8'h6F, 3'd0, 5'd7, 0, 0, 2'd0, 2'd0, 0, 0, 0); // MTSP R6
        run_insn(16'h314C, 6'd19, 4'h1, 8'h2F, 3'd5, 5'd4, 0, 1, 2'd0, 2'd0, 0, 0, 0); // SLL
        run_insn(16'h314F, 6'd20, 4'h1, 8'h2F, 3'd5, 5'd5, 0, 1, 2'd0, 2'd0, 0, 0, 0); // SRA
        run_insn(16'hF300, 6'd21, 4'h3, 8'hAF, 3'd0, 5'd7, 0, 0, 2'd0, 2'd0, 0, 0, 0); // MFIH R3
        run_insn(16'hF301, 6'd22, 4'hA, 8'h3F, 3'd0, 5'd7, 0, 0, 2'd0, 2'd0, 0, 0, 0); // MTIH R3
        run_insn(16'h4D80, 6'd1,  4'h5, 8'h5F, 3'd1, 5'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0); // ADDIU R5
        run_insn(16'h4143, 6'd2,  4'h2, 8'h1F, 3'd3, 5'd0, 0, 1, 2'd0, 2'd0, 0, 0, 0); // ADDIU3
        run_insn(16'hE94C, 6'd6,  4'h1, 8'h12, 3'd0, 5'd2, 0, 0, 2'd0, 2'd0, 0, 0, 0); // AND
        run_insn(16'hE94D, 6'd7,  4'h1, 8'h12, 3'd0, 5'd3, 0, 0, 2'd0, 2'd0, 0, 0, 0); // OR
        run_insn(16'h0800, 6'd0,  4'hF, 8'hFF, 3'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0); // NOP
        run_insn(16'hFFFF, 6'd0,  4'hF, 8'hFF, 3'd0, 5'd0, 0, 0, 2'd0, 2'd0, 0, 0, 0); // unmatched

        // SW aborted by reset during MEM
        bus.IR_in = 16'hDA45;
        tick();
        tick();
        tick();
        chk("abort_mem_state", 32'(bus.state), 32'd3);
        chk("abort_mem_write", 32'(bus.Write), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_write_masked", 32'(bus.Write), 32'd0);
        chk("abort_send_default", 32'(bus.Send_Reg), 32'hFF);
        tick();
        chk("abort_state_if", 32'(bus.state), 32'd0);
        chk("abort_ld_ir_masked", 32'(bus.Load_IR), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_restart_state", 32'(bus.state), 32'd0);
        chk("abort_restart_ld_ir", 32'(bus.Load_IR), 32'd1);
        tick();
        chk("abort_restart_id", 32'(bus.state), 32'd1);
        $display("reset during MEM total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
